// File: rtl/mux2_arbiter.sv
// Round-robin owner of a shared 2:1 mux: picks d0 or d1, presents it on a
// valid/ready port, holds the grant until transfer or abort, counts transfers.
module mux2_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             out_valid,
    output logic             sel,
    output logic             gnt0,
    output logic             gnt1,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic               sel_r, sel_s;
    logic               last_r, last_s;
    logic [CNT_W-1:0]   cnt0_r, cnt0_s;
    logic [CNT_W-1:0]   cnt1_r, cnt1_s;
    logic               owner_req_s;
    logic               xfer_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] top;
        top = {CNT_W{1'b1}};
        return (v == top) ? v : v + CNT_W'(1);
    endfunction

    assign owner_req_s = sel_r ? req1 : req0;
    // A transfer needs the owner still requesting; an abort in the same cycle wins.
    assign xfer_s      = (state_r == BUSY) && owner_req_s && out_ready;

    assign z         = sel_r ? d1 : d0;
    assign out_valid = (state_r == BUSY);
    assign sel       = sel_r;
    assign gnt0      = xfer_s && !sel_r;
    assign gnt1      = xfer_s && sel_r;
    assign cnt0      = cnt0_r;
    assign cnt1      = cnt1_r;

    // Next-state, owner selection and counter update.
    always_comb begin
        state_s = state_r;
        sel_s   = sel_r;
        last_s  = last_r;
        cnt0_s  = cnt0_r;
        cnt1_s  = cnt1_r;
        case (state_r)
            IDLE: begin
                if (req0 && req1) begin
                    sel_s   = ~last_r;
                    state_s = BUSY;
                end else if (req0) begin
                    sel_s   = 1'b0;
                    state_s = BUSY;
                end else if (req1) begin
                    sel_s   = 1'b1;
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (!owner_req_s) begin
                    state_s = IDLE;
                end else if (out_ready) begin
                    last_s  = sel_r;
                    state_s = IDLE;
                    if (sel_r) begin
                        cnt1_s = sat_inc(cnt1_r);
                    end else begin
                        cnt0_s = sat_inc(cnt0_r);
                    end
                end else begin
                    state_s = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State registers; last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            sel_r   <= 1'b0;
            last_r  <= 1'b1;
            cnt0_r  <= {CNT_W{1'b0}};
            cnt1_r  <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            sel_r   <= sel_s;
            last_r  <= last_s;
            cnt0_r  <= cnt0_s;
            cnt1_r  <= cnt1_s;
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Randomized and directed checks of mux2_arbiter against a transaction-level
// model of ownership, round-robin history and saturating counts.
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, out_ready;
    logic [7:0] d0, d1;

    logic [7:0] z_a, z_b;
    logic       out_valid_a, out_valid_b, sel_a, sel_b;
    logic       gnt0_a, gnt1_a, gnt0_b, gnt1_b;
    logic [7:0] cnt0_a, cnt1_a;
    logic [1:0] cnt0_b, cnt1_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: idle/busy, current owner, last winner, transfer counts.
    bit m_busy;
    int m_sel;
    int m_last;
    int m_cnt_a[2];
    int m_cnt_b[2];
    bit m_gnt_prev[2];

    mux2_arbiter #(.WIDTH(8), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .out_ready(out_ready), .z(z_a), .out_valid(out_valid_a), .sel(sel_a),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .cnt0(cnt0_a), .cnt1(cnt1_a)
    );

    mux2_arbiter #(.WIDTH(8), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .out_ready(out_ready), .z(z_b), .out_valid(out_valid_b), .sel(sel_b),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .cnt0(cnt0_b), .cnt1(cnt1_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_sel  = 0;
        m_last = 1;
        for (int i = 0; i < 2; i++) begin
            m_cnt_a[i]    = 0;
            m_cnt_b[i]    = 0;
            m_gnt_prev[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        bit   own_req;
        bit   e_g0, e_g1;
        logic [7:0] e_z;
        own_req = (m_sel == 1) ? req1 : req0;
        e_g0 = m_busy && (m_sel == 0) && own_req && out_ready;
        e_g1 = m_busy && (m_sel == 1) && own_req && out_ready;
        e_z  = (m_sel == 1) ? d1 : d0;
        chk("valid_a", 32'(out_valid_a), 32'(m_busy));
        chk("valid_b", 32'(out_valid_b), 32'(m_busy));
        chk("sel_a",   32'(sel_a),       32'(m_sel));
        chk("z_a",     32'(z_a),         32'(e_z));
        chk("z_b",     32'(z_b),         32'(e_z));
        chk("gnt0_a",  32'(gnt0_a),      32'(e_g0));
        chk("gnt1_a",  32'(gnt1_a),      32'(e_g1));
        chk("gnt0_b",  32'(gnt0_b),      32'(e_g0));
        chk("gnt1_b",  32'(gnt1_b),      32'(e_g1));
        chk("cnt0_a",  32'(cnt0_a),      32'(m_cnt_a[0]));
        chk("cnt1_a",  32'(cnt1_a),      32'(m_cnt_a[1]));
        chk("cnt0_b",  32'(cnt0_b),      32'(m_cnt_b[0]));
        chk("cnt1_b",  32'(cnt1_b),      32'(m_cnt_b[1]));
    endtask

    // Advance the model by one clock using the inputs the edge will sample.
    task automatic advance();
        bit own_req;
        m_gnt_prev[0] = 1'b0;
        m_gnt_prev[1] = 1'b0;
        if (m_busy) begin
            own_req = (m_sel == 1) ? req1 : req0;
            if (!own_req) begin
                m_busy = 1'b0;
            end else if (out_ready) begin
                m_last = m_sel;
                if (m_cnt_a[m_sel] < 255) m_cnt_a[m_sel]++;
                if (m_cnt_b[m_sel] < 3)   m_cnt_b[m_sel]++;
                m_gnt_prev[m_sel] = 1'b1;
                m_busy = 1'b0;
            end
        end else if (req0 || req1) begin
            m_busy = 1'b1;
            if (req0 && req1) m_sel = 1 - m_last;
            else              m_sel = req1 ? 1 : 0;
        end
    endtask

    task automatic step(input logic r0, input logic r1, input logic [7:0] a0,
                        input logic [7:0] a1, input logic rdy);
        @(negedge clk);
        req0 = r0; req1 = r1; d0 = a0; d1 = a1; out_ready = rdy;
        #1;
        check_all();
        advance();
    endtask

    logic       rq0, rq1;
    logic [7:0] rd0, rd1;

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 8'h00; d1 = 8'h00; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid_a), 32'd0);
        chk("rst_sel",   32'(sel_a),       32'd0);
        chk("rst_cnt0",  32'(cnt0_a),      32'd0);
        chk("rst_gnt0",  32'(gnt0_a),      32'd0);

        // Single requester with ready downstream.
        step(1'b1, 1'b0, 8'hA5, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'hA5, 8'h00, 1'b1);
        chk("a5_z",    32'(z_a),    32'hA5);
        chk("a5_gnt0", 32'(gnt0_a), 32'd1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("a5_cnt0", 32'(cnt0_a), 32'd1);

        // Continuous tie alternates owners.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("rr_cnt0", 32'(cnt0_a), 32'd3);
        chk("rr_cnt1", 32'(cnt1_a), 32'd2);

        // Stall with requester 1 owning.
        step(1'b0, 1'b1, 8'h00, 8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00, 8'h3C, 1'b0);
            chk("stall_sel", 32'(sel_a), 32'd1);
            chk("stall_z",   32'(z_a),   32'h3C);
        end
        step(1'b0, 1'b1, 8'h00, 8'h3C, 1'b1);
        chk("stall_gnt1", 32'(gnt1_a), 32'd1);

        // Abort by owner 0, then a tie must go to requester 0 again (last was 1).
        step(1'b1, 1'b0, 8'h44, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h44, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h44, 8'h00, 1'b1);
        chk("abort_gnt0", 32'(gnt0_a), 32'd0);
        step(1'b1, 1'b1, 8'h55, 8'h66, 1'b0);
        chk("abort_idle", 32'(out_valid_a), 32'd0);
        step(1'b1, 1'b1, 8'h55, 8'h66, 1'b1);
        chk("abort_tie_sel", 32'(sel_a), 32'd0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Asynchronous reset while busy.
        step(1'b1, 1'b0, 8'h77, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h77, 8'h00, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("pre_rst_gnt0", 32'(gnt0_a), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid_a), 32'd0);
        chk("arst_gnt0",  32'(gnt0_a),      32'd0);
        req0 = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_cnt0", 32'(cnt0_a), 32'd0);
        chk("arst_sel",  32'(sel_a),  32'd0);

        // Saturation: five transfers on requester 0.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h5A, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("sat_cnt0_b", 32'(cnt0_b), 32'd3);
        chk("sat_cnt0_a", 32'(cnt0_a), 32'd5);

        // Random traffic obeying the requester protocol, with occasional aborts.
        rq0 = 1'b0; rq1 = 1'b0; rd0 = 8'h00; rd1 = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if (rq0 && !m_gnt_prev[0]) begin
                if ($urandom_range(0, 15) == 0) rq0 = 1'b0;
            end else begin
                rq0 = ($urandom_range(0, 3) != 0);
                rd0 = 8'($urandom);
            end
            if (rq1 && !m_gnt_prev[1]) begin
                if ($urandom_range(0, 15) == 0) rq1 = 1'b0;
            end else begin
                rq1 = ($urandom_range(0, 3) != 0);
                rd1 = 8'($urandom);
            end
            step(rq0, rq1, rd0, rd1, ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
